// File: rtl/pulse_shaper.sv
// Array of independent pulse stretchers with programmable length, holdoff,
// retrigger and edge/level trigger selection, plus sticky overrun flags.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | o low, waiting for a trigger
// ACTIVE  | o high, cnt counts remaining pulse cycles down to 0
// HOLDOFF | o forced low, hcnt counts remaining holdoff cycles down to 0
module pulse_shaper #(
    parameter int DATAWIDTH = 8,
    parameter int CNTWIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [DATAWIDTH-1:0] i,
    input  logic [CNTWIDTH-1:0]  len,
    input  logic [CNTWIDTH-1:0]  holdoff,
    input  logic                 retrig,
    input  logic                 edge_mode,
    input  logic                 clr_overrun,
    output logic [DATAWIDTH-1:0] o,
    output logic [DATAWIDTH-1:0] overrun,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [CNTWIDTH-1:0] ONE = CNTWIDTH'(1);

    state_t              state_q [DATAWIDTH];
    state_t              state_d [DATAWIDTH];
    logic [CNTWIDTH-1:0] cnt_q   [DATAWIDTH];
    logic [CNTWIDTH-1:0] cnt_d   [DATAWIDTH];
    logic [CNTWIDTH-1:0] hcnt_q  [DATAWIDTH];
    logic [CNTWIDTH-1:0] hcnt_d  [DATAWIDTH];

    logic [DATAWIDTH-1:0] i_d;
    logic [DATAWIDTH-1:0] trig;
    logic [DATAWIDTH-1:0] o_d;
    logic [DATAWIDTH-1:0] overrun_d;
    logic [DATAWIDTH-1:0] chan_busy;
    logic [CNTWIDTH-1:0]  len_eff;

    assign len_eff = (len == '0) ? ONE : len;
    assign trig    = edge_mode ? (i & ~i_d) : i;
    assign busy    = |chan_busy;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            i_d     <= '0;
            o       <= '0;
            overrun <= '0;
            for (int x = 0; x < DATAWIDTH; x++) begin
                state_q[x] <= IDLE;
                cnt_q[x]   <= '0;
                hcnt_q[x]  <= '0;
            end
        end else begin
            i_d     <= i;
            o       <= o_d;
            overrun <= overrun_d;
            for (int x = 0; x < DATAWIDTH; x++) begin
                state_q[x] <= state_d[x];
                cnt_q[x]   <= cnt_d[x];
                hcnt_q[x]  <= hcnt_d[x];
            end
        end
    end

    always_comb begin
        for (int x = 0; x < DATAWIDTH; x++) begin
            state_d[x]   = state_q[x];
            cnt_d[x]     = cnt_q[x];
            hcnt_d[x]    = hcnt_q[x];
            o_d[x]       = o[x];
            // Clear first so a same-cycle set below takes priority.
            overrun_d[x] = overrun[x] & ~clr_overrun;
            chan_busy[x] = (state_q[x] != IDLE);

            case (state_q[x])
                IDLE: begin
                    if (trig[x]) begin
                        o_d[x]     = 1'b1;
                        cnt_d[x]   = len_eff - ONE;
                        state_d[x] = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (trig[x] && !retrig) begin
                        overrun_d[x] = 1'b1;
                    end
                    // An ignored trigger does not stall the countdown.
                    if (trig[x] && retrig) begin
                        cnt_d[x] = len_eff - ONE;
                    end else if (cnt_q[x] != '0) begin
                        cnt_d[x] = cnt_q[x] - ONE;
                    end else if (holdoff == '0) begin
                        o_d[x]     = 1'b0;
                        state_d[x] = IDLE;
                    end else begin
                        o_d[x]     = 1'b0;
                        hcnt_d[x]  = holdoff - ONE;
                        state_d[x] = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    o_d[x] = 1'b0;
                    if (trig[x]) begin
                        overrun_d[x] = 1'b1;
                    end
                    if (hcnt_q[x] != '0) begin
                        hcnt_d[x] = hcnt_q[x] - ONE;
                    end else begin
                        state_d[x] = IDLE;
                    end
                end
                default: begin
                    o_d[x]     = 1'b0;
                    state_d[x] = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_shaper.sv
// Scoreboard bench for pulse_shaper: directed scenarios queue expected output
// values per cycle, and a negedge monitor retires them against the DUT.
module tb_pulse_shaper;

    localparam int DW = 8;
    localparam int CW = 8;

    localparam int K_OBIT   = 0;
    localparam int K_OVR    = 1;
    localparam int K_BUSY   = 2;
    localparam int K_OVEC   = 3;
    localparam int K_OVRVEC = 4;

    logic          clk = 1'b0;
    logic          reset_l;
    logic [DW-1:0] i;
    logic [CW-1:0] len;
    logic [CW-1:0] holdoff;
    logic          retrig;
    logic          edge_mode;
    logic          clr_overrun;
    logic [DW-1:0] o;
    logic [DW-1:0] overrun;
    logic          busy;

    pulse_shaper #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .i           (i),
        .len         (len),
        .holdoff     (holdoff),
        .retrig      (retrig),
        .edge_mode   (edge_mode),
        .clr_overrun (clr_overrun),
        .o           (o),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        int         idx;
        logic [7:0] val;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    int  base     = 0;

    function automatic string kname(input int k);
        case (k)
            K_OBIT:   return "o_bit";
            K_OVR:    return "overrun_bit";
            K_BUSY:   return "busy";
            K_OVEC:   return "o_vec";
            default:  return "overrun_vec";
        endcase
    endfunction

    function automatic void push(input int c, input int k, input int idx, input logic [7:0] v);
        sb_t e;
        e.cyc  = c;
        e.kind = k;
        e.idx  = idx;
        e.val  = v;
        sb.push_back(e);
    endfunction

    // Expect 1 inside [a0,a1] or [b0,b1], 0 elsewhere, for cycles c0..c1 relative to base.
    function automatic void push_win(input int k, input int idx, input int c0, input int c1,
                                     input int a0, input int a1, input int b0, input int b1);
        for (int c = c0; c <= c1; c++)
            push(base + c, k, idx, ((c >= a0 && c <= a1) || (c >= b0 && c <= b1)) ? 8'd1 : 8'd0);
    endfunction

    task automatic check(input sb_t e);
        logic [7:0] act;
        case (e.kind)
            K_OBIT:  act = {7'd0, o[e.idx]};
            K_OVR:   act = {7'd0, overrun[e.idx]};
            K_BUSY:  act = {7'd0, busy};
            K_OVEC:  act = o;
            default: act = overrun;
        endcase
        n_checks++;
        if (act === e.val)
            n_pass++;
        else
            $display("FAIL %s[%0d] cycle %0d (rel %0d): got %0h expected %0h",
                     kname(e.kind), e.idx, e.cyc, e.cyc - base, act, e.val);
    endtask

    always @(negedge clk) begin : monitor
        int k;
        k = 0;
        while (k < sb.size()) begin
            if (sb[k].cyc < cyc) begin
                n_checks++;
                $display("FAIL stale_%s[%0d] cycle %0d: not sampled, expected %0h",
                         kname(sb[k].kind), sb[k].idx, sb[k].cyc, sb[k].val);
                sb.delete(k);
            end else if (sb[k].cyc == cyc) begin
                check(sb[k]);
                sb.delete(k);
            end else begin
                k++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scn_start();
        i           = '0;
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        base        = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_l     = 1'b0;
        i           = '0;
        len         = 8'd1;
        holdoff     = '0;
        retrig      = 1'b0;
        edge_mode   = 1'b0;
        clr_overrun = 1'b0;

        step();
        push(cyc + 1, K_OVEC,   0, 8'h00);
        push(cyc + 1, K_OVRVEC, 0, 8'h00);
        push(cyc + 1, K_BUSY,   0, 8'h00);
        step();
        reset_l = 1'b1;
        step();

        // Isolated level trigger, len 6
        len = 8'd6; holdoff = 8'd0; retrig = 1'b0; edge_mode = 1'b0;
        scn_start();
        push_win(K_OBIT, 0, 9, 18, 11, 16, 1, 0);
        push_win(K_BUSY, 0, 9, 18, 11, 16, 1, 0);
        push(base + 18, K_OVR, 0, 8'd0);
        for (int n = 1; n <= 20; n++) begin
            step();
            i = (n == 10) ? 8'h01 : 8'h00;
        end

        // Retrigger extends the pulse
        len = 8'd4; retrig = 1'b1;
        scn_start();
        push_win(K_OBIT, 1, 9, 19, 11, 17, 1, 0);
        push(base + 19, K_OVR, 1, 8'd0);
        for (int n = 1; n <= 20; n++) begin
            step();
            i = (n == 10 || n == 13) ? 8'h02 : 8'h00;
        end

        // Same triggers without retrigger: overrun, then cleared
        retrig = 1'b0;
        scn_start();
        push_win(K_OBIT, 1, 9, 19, 11, 14, 1, 0);
        push_win(K_OVR,  1, 12, 22, 14, 20, 1, 0);
        for (int n = 1; n <= 23; n++) begin
            step();
            i           = (n == 10 || n == 13) ? 8'h02 : 8'h00;
            clr_overrun = (n == 20);
        end

        // Holdoff window
        len = 8'd3; holdoff = 8'd5; retrig = 1'b0;
        scn_start();
        push_win(K_OBIT, 2, 9, 24, 11, 13, 20, 22);
        push_win(K_BUSY, 0, 9, 29, 11, 18, 20, 27);
        push_win(K_OVR,  2, 9, 25, 16, 25, 1, 0);
        for (int n = 1; n <= 30; n++) begin
            step();
            i = (n == 10 || n == 15 || n == 19) ? 8'h04 : 8'h00;
        end

        // Edge mode, held input gives one pulse
        len = 8'd2; holdoff = 8'd0; retrig = 1'b0; edge_mode = 1'b1;
        scn_start();
        push_win(K_OBIT, 3, 9, 34, 11, 12, 1, 0);
        push(base + 34, K_OVR, 3, 8'd0);
        for (int n = 1; n <= 35; n++) begin
            step();
            i = (n >= 10 && n <= 30) ? 8'h08 : 8'h00;
        end

        // Level mode with retrigger, held input
        edge_mode = 1'b0; retrig = 1'b1;
        scn_start();
        push_win(K_OBIT, 3, 9, 35, 11, 32, 1, 0);
        push(base + 35, K_OVR, 3, 8'd0);
        for (int n = 1; n <= 36; n++) begin
            step();
            i = (n >= 10 && n <= 30) ? 8'h08 : 8'h00;
        end

        // len 0 behaves as 1
        len = 8'd0; retrig = 1'b0;
        scn_start();
        push_win(K_OBIT, 4, 9, 13, 11, 11, 1, 0);
        for (int n = 1; n <= 14; n++) begin
            step();
            i = (n == 10) ? 8'h10 : 8'h00;
        end

        // Overrun set beats simultaneous clear
        len = 8'd4; retrig = 1'b0;
        scn_start();
        push_win(K_OBIT, 5, 9, 16, 11, 14, 1, 0);
        push_win(K_OVR,  5, 9, 17, 13, 15, 1, 0);
        for (int n = 1; n <= 18; n++) begin
            step();
            i           = (n == 10 || n == 12) ? 8'h20 : 8'h00;
            clr_overrun = (n == 12 || n == 15);
        end

        // Asynchronous reset mid-pulse, then a full pulse afterwards
        len = 8'd10;
        scn_start();
        push_win(K_OBIT, 6, 9, 30, 11, 13, 19, 28);
        push_win(K_BUSY, 0, 13, 30, 11, 13, 19, 28);
        push(base + 14, K_OVEC,   0, 8'h00);
        push(base + 15, K_OVRVEC, 0, 8'h00);
        for (int n = 1; n <= 31; n++) begin
            step();
            i = (n == 10 || n == 18) ? 8'h40 : 8'h00;
            if (n == 14) reset_l = 1'b0;
            if (n == 16) reset_l = 1'b1;
        end

        // All channels, maximum length
        len = 8'd255; holdoff = 8'd0; retrig = 1'b0;
        scn_start();
        for (int c = 9; c <= 268; c++)
            push(base + c, K_OVEC, 0, (c >= 11 && c <= 265) ? 8'hFF : 8'h00);
        push_win(K_BUSY, 0, 9, 268, 11, 265, 1, 0);
        push(base + 268, K_OVRVEC, 0, 8'h00);
        for (int n = 1; n <= 270; n++) begin
            step();
            i = (n == 10) ? 8'hFF : 8'h00;
        end

        step();
        step();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
